// File: rtl/ps2_key_event_if.sv
// ============================================================================
// Module   : ps2_key_event_if
// Brief    : PS/2 pin inputs and decoded key-event outputs of ps2_key_event.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_key_event_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_data;
  logic       key_ext;
  logic       key_rel;
  logic [7:0] rel_code;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output key_data, key_ext, key_rel, rel_code, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_data, key_ext, key_rel, rel_code, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_event.sv
// ============================================================================
// Module   : ps2_key_event
// Brief    : PS/2 set-2 frame receiver producing single-cycle make/break events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_event #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100_000,
  parameter bit PASS_EXT    = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  ps2_key_event_if.master bus
);

  localparam int              c_TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      c_FMAX = 4'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [1:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  logic            r_filt;
  logic [3:0]      r_fcnt;
  state_t          r_state;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic            r_brk;
  logic            r_ext;
  logic [c_TW-1:0] r_tcnt;
  logic [7:0]      r_key_data;
  logic            r_key_ext;
  logic            r_key_rel;
  logic [7:0]      r_rel_code;
  logic            r_frame_err;

  logic w_fall;
  logic w_bit;
  logic w_good;

  // Sync FFs reset high so an idle bus shows no edge straight out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], bus.ps2_clk};
      r_dat_sync <= {r_dat_sync[0], bus.ps2_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= 1'b1;
      r_fcnt <= 4'd0;
    end else if (r_clk_sync[1] == r_filt) begin
      r_fcnt <= 4'd0;
    end else if (r_fcnt == c_FMAX) begin
      r_filt <= r_clk_sync[1];
      r_fcnt <= 4'd0;
    end else begin
      r_fcnt <= r_fcnt + 4'd1;
    end
  end

  assign w_fall = r_filt && !r_clk_sync[1] && (r_fcnt == c_FMAX);
  assign w_bit  = r_dat_sync[1];
  assign w_good = w_bit && ((^r_shift) ^ r_parity);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'h00;
      r_parity    <= 1'b0;
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_tcnt      <= '0;
      r_key_data  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_rel   <= 1'b0;
      r_rel_code  <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_key_data  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_rel   <= 1'b0;
      r_frame_err <= 1'b0;

      if (w_fall) begin
        r_tcnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_bit) begin
              r_state  <= S_DATA;
              r_bitcnt <= 3'd0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= w_bit;
            r_state  <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (!w_good) begin
              r_frame_err <= 1'b1;
              r_brk       <= 1'b0;
              r_ext       <= 1'b0;
            end else if (r_shift == 8'hE0) begin
              r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_brk <= 1'b1;
            end else if (r_brk) begin
              r_rel_code <= r_shift;
              r_key_rel  <= 1'b1;
              r_key_ext  <= r_ext;
              r_brk      <= 1'b0;
              r_ext      <= 1'b0;
            end else begin
              // BAT/zero bytes and suppressed extended makes never reach key_data
              if ((r_shift != 8'h00) && (r_shift != 8'hAA) && (!r_ext || PASS_EXT)) begin
                r_key_data <= r_shift;
                r_key_ext  <= r_ext;
              end
              r_ext <= 1'b0;
            end
          end
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_tcnt == c_TMAX) begin
          r_state     <= S_IDLE;
          r_frame_err <= 1'b1;
          r_brk       <= 1'b0;
          r_ext       <= 1'b0;
          r_tcnt      <= '0;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end else begin
        r_tcnt <= '0;
      end
    end
  end

  assign bus.key_data  = r_key_data;
  assign bus.key_ext   = r_key_ext;
  assign bus.key_rel   = r_key_rel;
  assign bus.rel_code  = r_rel_code;
  assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_event.sv
// ============================================================================
// Module   : tb_ps2_key_event
// Brief    : Self-checking bench driving two receivers (PASS_EXT 0 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_event;

  localparam int c_FL   = 8;
  localparam int c_TO   = 400;
  localparam int c_HALF = 40;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  always #5 clk = ~clk;

  ps2_key_event_if bus0 ();
  ps2_key_event_if bus1 ();

  assign bus0.ps2_clk  = ps2_clk;
  assign bus0.ps2_data = ps2_data;
  assign bus1.ps2_clk  = ps2_clk;
  assign bus1.ps2_data = ps2_data;

  ps2_key_event #(.FILTER_LEN(c_FL), .TIMEOUT_CYC(c_TO), .PASS_EXT(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  ps2_key_event #(.FILTER_LEN(c_FL), .TIMEOUT_CYC(c_TO), .PASS_EXT(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  typedef struct packed {
    logic [7:0] kd;
    logic       ke;
    logic       kr;
    logic [7:0] rc;
    logic       fe;
  } ev_t;

  ev_t        exp_q [2][$];
  bit         m_brk [2];
  bit         m_ext [2];
  logic [7:0] model_rel [2];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_kd  [2];
  int         n_rel [2];
  int         n_err [2];
  logic [7:0] last_kd [2];
  logic       last_ke [2];

  function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
  endfunction

  // Byte-level model: what each complete frame must produce on the event outputs
  task automatic model_frame(input int d, input logic [7:0] b, input bit good);
    ev_t e;
    e = '0;
    if (!good) begin
      e.fe = 1'b1;
      exp_q[d].push_back(e);
      m_brk[d] = 1'b0;
      m_ext[d] = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext[d] = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk[d] = 1'b1;
    end else if (m_brk[d]) begin
      e.kr = 1'b1;
      e.rc = b;
      e.ke = m_ext[d];
      exp_q[d].push_back(e);
      m_brk[d] = 1'b0;
      m_ext[d] = 1'b0;
    end else begin
      if (b != 8'h00 && b != 8'hAA && (!m_ext[d] || d == 1)) begin
        e.kd = b;
        e.ke = m_ext[d];
        exp_q[d].push_back(e);
      end
      m_ext[d] = 1'b0;
    end
  endtask

  function automatic void cmp(int d, logic [7:0] kd, logic ke, logic kr, logic [7:0] rc, logic fe);
    ev_t a, e;
    a.kd = kd;
    a.ke = ke;
    a.kr = kr;
    a.rc = kr ? rc : 8'h00;
    a.fe = fe;
    if (kd != 8'h00 || ke || kr || fe) begin
      if (exp_q[d].size() == 0) begin
        chk("unexpected_event", d, 32'(a), 32'h0);
      end else begin
        e = exp_q[d].pop_front();
        if (e.kr) model_rel[d] = e.rc;
        chk("event", d, 32'(a), 32'(e));
      end
      if (kd != 8'h00) begin
        n_kd[d]++;
        last_kd[d] = kd;
        last_ke[d] = ke;
      end
      if (kr) n_rel[d]++;
      if (fe) n_err[d]++;
    end
    chk("rel_code_hold", d, 32'(rc), 32'(model_rel[d]));
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, bus0.key_data, bus0.key_ext, bus0.key_rel, bus0.rel_code, bus0.frame_err);
      cmp(1, bus1.key_data, bus1.key_ext, bus1.key_rel, bus1.rel_code, bus1.frame_err);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      n_kd[d]    = 0;
      n_rel[d]   = 0;
      n_err[d]   = 0;
      last_kd[d] = 8'h00;
      last_ke[d] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      m_brk[d]     = 1'b0;
      m_ext[d]     = 1'b0;
      model_rel[d] = 8'h00;
    end
    cyc(n);
    rst = 1'b0;
    cyc(2);
  endtask

  // Bit 0 = start, 1..8 = data LSB first, 9 = odd parity, 10 = stop
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch && i == 3) begin
        cyc(10);
        ps2_clk = 1'b0;
        cyc(c_FL - 1);
        ps2_clk = 1'b1;
        cyc(c_HALF - 10 - (c_FL - 1));
      end else begin
        cyc(c_HALF);
      end
      ps2_clk = 1'b0;
      cyc(c_HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_q", 0, 32'(exp_q[0].size()), 32'd0);
    chk("drain_q", 1, 32'(exp_q[1].size()), 32'd0);
    cyc(c_HALF);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    model_frame(0, b, !bad_par);
    model_frame(1, b, !bad_par);
    send_bits(b, bad_par, glitch, 11);
    drain();
  endtask

  task automatic outputs_zero(input string name);
    chk(name, 0, 32'({bus0.key_data, bus0.key_ext, bus0.key_rel, bus0.rel_code, bus0.frame_err}), 32'd0);
    chk(name, 1, 32'({bus1.key_data, bus1.key_ext, bus1.key_rel, bus1.rel_code, bus1.frame_err}), 32'd0);
  endtask

  initial begin
    clear_counts();
    do_reset(5);
    cyc(2);
    outputs_zero("reset_outputs");

    // Plain make
    clear_counts();
    frame(8'h3A, 1'b0, 1'b0);
    chk("make_count", 0, 32'(n_kd[0]), 32'd1);
    chk("make_code", 0, 32'(last_kd[0]), 32'h3A);
    chk("make_ext", 0, 32'(last_ke[0]), 32'd0);
    chk("make_err", 0, 32'(n_err[0]), 32'd0);

    // Typematic repeat
    clear_counts();
    frame(8'h3A, 1'b0, 1'b0);
    frame(8'h3A, 1'b0, 1'b0);
    chk("typematic_count", 0, 32'(n_kd[0]), 32'd2);

    // Break sequence
    clear_counts();
    frame(8'hF0, 1'b0, 1'b0);
    frame(8'h3A, 1'b0, 1'b0);
    chk("break_no_make", 0, 32'(n_kd[0]), 32'd0);
    chk("break_rel_count", 0, 32'(n_rel[0]), 32'd1);
    chk("break_rel_code", 0, 32'(bus0.rel_code), 32'h3A);

    // Extended make, both PASS_EXT settings
    clear_counts();
    frame(8'hE0, 1'b0, 1'b0);
    frame(8'h6B, 1'b0, 1'b0);
    chk("ext_suppressed", 0, 32'(n_kd[0]), 32'd0);
    chk("ext_pass_count", 1, 32'(n_kd[1]), 32'd1);
    chk("ext_pass_code", 1, 32'(last_kd[1]), 32'h6B);
    chk("ext_pass_flag", 1, 32'(last_ke[1]), 32'd1);

    // Extended break
    clear_counts();
    frame(8'hE0, 1'b0, 1'b0);
    frame(8'hF0, 1'b0, 1'b0);
    frame(8'h6B, 1'b0, 1'b0);
    chk("ext_break_rel", 0, 32'(n_rel[0]), 32'd1);
    chk("ext_break_rel", 1, 32'(n_rel[1]), 32'd1);
    chk("ext_break_code", 1, 32'(bus1.rel_code), 32'h6B);

    // BAT byte is swallowed
    clear_counts();
    frame(8'hAA, 1'b0, 1'b0);
    chk("bat_no_make", 0, 32'(n_kd[0]), 32'd0);

    // Parity error, then recovery
    clear_counts();
    frame(8'h29, 1'b1, 1'b0);
    chk("parity_err_count", 0, 32'(n_err[0]), 32'd1);
    chk("parity_no_make", 0, 32'(n_kd[0]), 32'd0);
    frame(8'h29, 1'b0, 1'b0);
    chk("parity_recover", 0, 32'(last_kd[0]), 32'h29);

    // Timeout after four data bits
    clear_counts();
    model_frame(0, 8'h00, 1'b0);
    model_frame(1, 8'h00, 1'b0);
    send_bits(8'h55, 1'b0, 1'b0, 5);
    cyc(c_TO + 100);
    drain();
    chk("timeout_err_count", 0, 32'(n_err[0]), 32'd1);
    frame(8'h12, 1'b0, 1'b0);
    chk("timeout_recover", 0, 32'(last_kd[0]), 32'h12);
    chk("timeout_make_count", 0, 32'(n_kd[0]), 32'd1);

    // Glitches in idle and mid-frame are filtered out
    clear_counts();
    ps2_clk = 1'b0;
    cyc(c_FL - 1);
    ps2_clk = 1'b1;
    cyc(50);
    frame(8'h1C, 1'b0, 1'b1);
    chk("glitch_make", 0, 32'(last_kd[0]), 32'h1C);
    chk("glitch_err", 0, 32'(n_err[0]), 32'd0);

    // Reset in the middle of a frame
    clear_counts();
    send_bits(8'h77, 1'b0, 1'b0, 6);
    do_reset(4);
    outputs_zero("midframe_reset_outputs");
    frame(8'h5A, 1'b0, 1'b0);
    chk("post_reset_make", 0, 32'(last_kd[0]), 32'h5A);
    chk("post_reset_count", 0, 32'(n_kd[0]), 32'd1);
    chk("post_reset_err", 0, 32'(n_err[0]), 32'd0);

    cyc(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
